dtw_core_ctrl: RTL and testbench
================================

Name: dtw_core_ctrl

Overview:
- Sequencer for one DTW core datapath instance.
- Accepts a job (reference length) from the host, clears the datapath, and streams the squiggle and reference samples into it in lockstep.
- Stalls the datapath whenever an input stream is starved, and pads the reference once it is exhausted.
- Detects completion, then returns minval and position through a valid/ready result port.
- Sits between the host/DMA sample streams and the DTW datapath.

Parameters:
- width, 16, sample and DTW score width.
- SQG_SIZE, 256, PE count; number of squiggle samples per job.
- CLR_CYCLES, 2, number of cycles dp_rst is held high before a run.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  job request pulse; accepted only in IDLE.
- start_ref_len  in  32  reference length for the job.
- abort  in  1  cancel the current job.
- busy  out  1  high when state is not IDLE.
- sqg_data  in  width  squiggle sample.
- sqg_valid  in  1  squiggle handshake valid.
- sqg_ready  out  1  squiggle handshake ready.
- ref_data  in  width  reference sample.
- ref_valid  in  1  reference handshake valid.
- ref_ready  out  1  reference handshake ready.
- res_minval  out  width  result score.
- res_position  out  32  result position.
- res_err  out  1  1 = job rejected because ref_len was 0.
- res_valid  out  1  result handshake valid.
- res_ready  in  1  result handshake ready.
- dp_rst  out  1  datapath synchronous reset.
- dp_running  out  1  datapath run enable.
- dp_squiggle  out  width  to datapath Input_squiggle.
- dp_rword  out  width  to datapath Rword.
- dp_ref_len  out  32  registered job length.
- dp_minval  in  width  from datapath.
- dp_position  in  32  from datapath.
- dp_done  in  1  from datapath.
- stall_count  out  32  number of starved RUN cycles in the current job.

Behaviour:
- Reset: rst_n low forces state to IDLE. While rst_n is low:
  - dp_rst=1.
  - dp_running, sqg_ready, ref_ready, res_valid, busy, res_err = 0.
  - res_minval = all-ones; res_position, dp_ref_len, stall_count = 0.
  - Internal counters are cleared.
- States: IDLE, CLEAR, PRIME, RUN, FINAL, CAPTURE, RESULT.
- IDLE:
  - start=1 and start_ref_len != 0: latch start_ref_len into dp_ref_len, clear counters and stall_count, go to CLEAR.
  - start=1 and start_ref_len == 0: go straight to RESULT with res_err=1, res_minval=all-ones, res_position=0.
- CLEAR: dp_rst=1 for CLR_CYCLES cycles, then go to PRIME; dp_running=0.
  - If CLEAR was entered via abort, it returns to IDLE instead of PRIME.
- PRIME:
  - Exactly one cycle with dp_running=1, no stream consumption, dp_rword=0, dp_squiggle=0.
  - Next state RUN.
- RUN, per cycle, with sc = squiggle count (0..SQG_SIZE) and rc = reference count (0..ref_len):
  - sq_ok = (sc==SQG_SIZE) | sqg_valid.
  - rf_ok = (rc==ref_len) | ref_valid.
  - step = sq_ok & rf_ok.
  - dp_running = step.
  - sqg_ready = step & (sc<SQG_SIZE).
  - ref_ready = step & (rc<ref_len).
  - Each handshake increments its counter.
  - dp_squiggle = sqg_data while sc<SQG_SIZE, else 0.
  - dp_rword = ref_data while rc<ref_len, else all-ones (pad).
  - A RUN cycle with step=0 increments stall_count; stall_count saturates at 2^32-1.
- Completion:
  - In RUN, dp_done=1 overrides the above: dp_running=1, both readies=0, next state FINAL.
  - dp_done has priority over stalls; no stall is counted in that cycle.
- FINAL: one cycle, dp_running=0, next state CAPTURE.
- CAPTURE: register dp_minval into res_minval and dp_position into res_position, set res_err=0, go to RESULT.
- RESULT:
  - res_valid=1 and stays high, with data held stable, until res_ready=1.
  - On res_ready=1, go to IDLE; res_valid falls on the next cycle.
- Readies are never asserted outside RUN, and dp_running is never asserted outside PRIME/RUN.
- start while busy is ignored; start must not be latched for later.
- abort:
  - Any state other than IDLE or CLEAR goes to CLEAR (dp_rst held CLR_CYCLES), then IDLE.
  - No result is produced and res_valid drops on the next cycle.
  - abort during CLEAR restarts the CLR_CYCLES count and marks the return path as IDLE.
  - abort in IDLE is ignored; abort and start in the same IDLE cycle means start is ignored.
- rst_n asserted mid-job behaves as an abort without a clear phase: immediate IDLE, with dp_rst held high while rst_n is low.
- Squiggle starvation after the squiggle load has finished, or reference starvation after padding has begun, cannot stall the datapath (the corresponding ok term is 1).
- Latency, with no stalls: from start acceptance to res_valid is CLR_CYCLES + 1 + (RUN cycles up to and including the dp_done cycle) + 2 cycles.

Test Plan:
1. SQG_SIZE=4, ref_len=6, both streams always valid with the real datapath:
   - exactly 4 squiggle and 6 reference handshakes;
   - res_valid rises with res_position=6 and res_minval equal to the golden DTW;
   - stall_count=0.
2. Same job with ref_valid low for 3 cycles mid-run:
   - dp_running=0 for exactly those 3 cycles;
   - stall_count=3;
   - res_minval identical to test 1.
3. start with start_ref_len=0:
   - RESULT reached on the next cycle with res_err=1, res_minval=0xFFFF, res_position=0;
   - no stream handshakes occur.
4. abort asserted 5 cycles into RUN:
   - readies drop on the next cycle;
   - dp_rst held high for 2 cycles;
   - IDLE reached and no res_valid.
   - A following normal job then matches test 1.
5. res_ready held low for 10 cycles:
   - res_valid and data stay stable;
   - a start pulse during this window is ignored (busy=1);
   - IDLE is reached one cycle after res_ready=1.
6. rst_n pulsed low during RUN:
   - all outputs take their reset values asynchronously and dp_rst=1;
   - after release, state is IDLE and the next job completes correctly.

Source files
------------

// File: rtl/dtw_core_ctrl.sv
// Sequencer for one DTW core datapath: accepts a job, clears and primes the datapath, streams
// squiggle/reference samples in lockstep (stall on starvation, pad exhausted reference), returns result.
module dtw_core_ctrl #(
    parameter int unsigned Width     = 16,
    parameter int unsigned SqgSize   = 256,
    parameter int unsigned ClrCycles = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [31:0]      start_ref_len_i,
    input  logic             abort_i,
    output logic             busy_o,
    input  logic [Width-1:0] sqg_data_i,
    input  logic             sqg_valid_i,
    output logic             sqg_ready_o,
    input  logic [Width-1:0] ref_data_i,
    input  logic             ref_valid_i,
    output logic             ref_ready_o,
    output logic [Width-1:0] res_minval_o,
    output logic [31:0]      res_position_o,
    output logic             res_err_o,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic             dp_rst_o,
    output logic             dp_running_o,
    output logic [Width-1:0] dp_squiggle_o,
    output logic [Width-1:0] dp_rword_o,
    output logic [31:0]      dp_ref_len_o,
    input  logic [Width-1:0] dp_minval_i,
    input  logic [31:0]      dp_position_i,
    input  logic             dp_done_i,
    output logic [31:0]      stall_count_o
);

    localparam int unsigned ScW = $clog2(SqgSize + 1);
    localparam int unsigned CcW = (ClrCycles > 1) ? $clog2(ClrCycles) : 1;
    localparam logic [ScW-1:0] SqgLast = ScW'(SqgSize);
    localparam logic [CcW-1:0] ClrLast = CcW'(ClrCycles - 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StPrime,
        StRun,
        StFinal,
        StCapture,
        StResult
    } state_e;

    state_e             state_q, state_d;
    logic [CcW-1:0]     clr_cnt_q, clr_cnt_d;
    logic               clr_to_idle_q, clr_to_idle_d;
    logic [ScW-1:0]     sc_q, sc_d;
    logic [31:0]        rc_q, rc_d;
    logic [31:0]        ref_len_q, ref_len_d;
    logic [31:0]        stall_q, stall_d;
    logic [Width-1:0]   res_minval_q, res_minval_d;
    logic [31:0]        res_position_q, res_position_d;
    logic               res_err_q, res_err_d;

    logic sq_more, rf_more, sq_ok, rf_ok, step;

    // An exhausted stream can never starve the datapath.
    assign sq_more = (sc_q < SqgLast);
    assign rf_more = (rc_q < ref_len_q);
    assign sq_ok   = ~sq_more | sqg_valid_i;
    assign rf_ok   = ~rf_more | ref_valid_i;
    assign step    = sq_ok & rf_ok;

    always_comb begin
        state_d        = state_q;
        clr_cnt_d      = clr_cnt_q;
        clr_to_idle_d  = clr_to_idle_q;
        sc_d           = sc_q;
        rc_d           = rc_q;
        ref_len_d      = ref_len_q;
        stall_d        = stall_q;
        res_minval_d   = res_minval_q;
        res_position_d = res_position_q;
        res_err_d      = res_err_q;
        sqg_ready_o    = 1'b0;
        ref_ready_o    = 1'b0;
        dp_running_o   = 1'b0;
        dp_squiggle_o  = '0;
        dp_rword_o     = '0;

        unique case (state_q)
            StIdle: begin
                if (start_i && !abort_i) begin
                    if (start_ref_len_i != 32'd0) begin
                        ref_len_d     = start_ref_len_i;
                        sc_d          = '0;
                        rc_d          = '0;
                        stall_d       = '0;
                        clr_cnt_d     = '0;
                        clr_to_idle_d = 1'b0;
                        res_err_d     = 1'b0;
                        state_d       = StClear;
                    end else begin
                        res_err_d      = 1'b1;
                        res_minval_d   = '1;
                        res_position_d = '0;
                        state_d        = StResult;
                    end
                end
            end
            StClear: begin
                if (clr_cnt_q == ClrLast) begin
                    clr_cnt_d = '0;
                    state_d   = clr_to_idle_q ? StIdle : StPrime;
                end else begin
                    clr_cnt_d = clr_cnt_q + CcW'(1);
                end
            end
            StPrime: begin
                dp_running_o = 1'b1;
                state_d      = StRun;
            end
            StRun: begin
                dp_squiggle_o = sq_more ? sqg_data_i : '0;
                dp_rword_o    = rf_more ? ref_data_i : '1;
                if (dp_done_i) begin
                    dp_running_o = 1'b1;
                    state_d      = StFinal;
                end else begin
                    dp_running_o = step;
                    sqg_ready_o  = step & sq_more;
                    ref_ready_o  = step & rf_more;
                    if (sqg_ready_o) sc_d = sc_q + ScW'(1);
                    if (ref_ready_o) rc_d = rc_q + 32'd1;
                    if (!step && (stall_q != '1)) stall_d = stall_q + 32'd1;
                end
            end
            StFinal: begin
                state_d = StCapture;
            end
            StCapture: begin
                res_minval_d   = dp_minval_i;
                res_position_d = dp_position_i;
                res_err_d      = 1'b0;
                state_d        = StResult;
            end
            StResult: begin
                if (res_ready_i) state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort from any active state runs a fresh clear phase that returns to idle.
        if (abort_i && (state_q != StIdle)) begin
            state_d       = StClear;
            clr_cnt_d     = '0;
            clr_to_idle_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= StIdle;
            clr_cnt_q      <= '0;
            clr_to_idle_q  <= 1'b0;
            sc_q           <= '0;
            rc_q           <= '0;
            ref_len_q      <= '0;
            stall_q        <= '0;
            res_minval_q   <= '1;
            res_position_q <= '0;
            res_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            clr_cnt_q      <= clr_cnt_d;
            clr_to_idle_q  <= clr_to_idle_d;
            sc_q           <= sc_d;
            rc_q           <= rc_d;
            ref_len_q      <= ref_len_d;
            stall_q        <= stall_d;
            res_minval_q   <= res_minval_d;
            res_position_q <= res_position_d;
            res_err_q      <= res_err_d;
        end
    end

    // Datapath reset also follows the async reset so it is held while rst_ni is low.
    assign dp_rst_o       = ~rst_ni | (state_q == StClear);
    assign busy_o         = (state_q != StIdle);
    assign res_valid_o    = (state_q == StResult);
    assign res_minval_o   = res_minval_q;
    assign res_position_o = res_position_q;
    assign res_err_o      = res_err_q;
    assign dp_ref_len_o   = ref_len_q;
    assign stall_count_o  = stall_q;

endmodule

// File: tb/tb_dtw_core_ctrl.sv
// Bench for dtw_core_ctrl: stream sources, a behavioural datapath stand-in and a golden DTW
// score, driven through directed and randomized jobs.
module tb_dtw_core_ctrl;
    localparam int unsigned W  = 16;
    localparam int unsigned SQ = 4;
    localparam int unsigned CC = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, abort_s, res_ready;
    logic [31:0]   start_ref_len;
    logic          busy;
    logic [W-1:0]  sqg_data, ref_data;
    logic          sqg_valid, ref_valid, sqg_ready, ref_ready;
    logic [W-1:0]  res_minval;
    logic [31:0]   res_position;
    logic          res_err, res_valid;
    logic          dp_rst, dp_running;
    logic [W-1:0]  dp_squiggle, dp_rword;
    logic [31:0]   dp_ref_len;
    logic [W-1:0]  dp_minval;
    logic [31:0]   dp_position;
    logic          dp_done;
    logic [31:0]   stall_count;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] sq_mem [SQ];
    logic [W-1:0] rf_mem [64];
    logic [W-1:0] gold;
    int ref_len, sqi, rfi, k, steps, sq_hs, rf_hs, run_idle, starved, res_k;
    int gap_lo, gap_hi;
    bit job_on, done_q, rand_gaps;
    logic [W-1:0] fed_sq[$];
    logic [W-1:0] fed_rf[$];

    dtw_core_ctrl #(.Width(W), .SqgSize(SQ), .ClrCycles(CC)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .start_ref_len_i(start_ref_len),
        .abort_i(abort_s), .busy_o(busy), .sqg_data_i(sqg_data), .sqg_valid_i(sqg_valid),
        .sqg_ready_o(sqg_ready), .ref_data_i(ref_data), .ref_valid_i(ref_valid),
        .ref_ready_o(ref_ready), .res_minval_o(res_minval), .res_position_o(res_position),
        .res_err_o(res_err), .res_valid_o(res_valid), .res_ready_i(res_ready),
        .dp_rst_o(dp_rst), .dp_running_o(dp_running), .dp_squiggle_o(dp_squiggle),
        .dp_rword_o(dp_rword), .dp_ref_len_o(dp_ref_len), .dp_minval_i(dp_minval),
        .dp_position_i(dp_position), .dp_done_i(dp_done), .stall_count_o(stall_count)
    );

    always #5 clk = ~clk;

    // Datapath stand-in reports the golden score and the job length as position.
    assign dp_minval   = gold;
    assign dp_position = dp_ref_len;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] dtw(input int n);
        int d [SQ][64];
        int c, m;
        for (int i = 0; i < SQ; i++) begin
            for (int j = 0; j < n; j++) begin
                c = int'(sq_mem[i]) - int'(rf_mem[j]);
                if (c < 0) c = -c;
                if (i == 0 && j == 0) m = 0;
                else if (i == 0) m = d[0][j-1];
                else if (j == 0) m = d[i-1][0];
                else begin
                    m = d[i-1][j-1];
                    if (d[i-1][j] < m) m = d[i-1][j];
                    if (d[i][j-1] < m) m = d[i][j-1];
                end
                d[i][j] = c + m;
            end
        end
        return W'(d[SQ-1][n-1]);
    endfunction

    // One clock cycle: called at a falling edge, drives sources, samples before the rising edge.
    task automatic cycle();
        bit starve;
        sqg_valid = 1'b1;
        ref_valid = 1'b1;
        if (k >= gap_lo && k < gap_hi) ref_valid = 1'b0;
        if (rand_gaps) begin
            sqg_valid = ($urandom_range(3) != 0);
            ref_valid = ($urandom_range(3) != 0);
        end
        sqg_data = (sqi < int'(SQ)) ? sq_mem[sqi] : 16'hDEAD;
        ref_data = (rfi < ref_len) ? rf_mem[rfi] : 16'hBEEF;
        dp_done  = done_q;
        #4;
        starve = (sqi < int'(SQ) && !sqg_valid) || (rfi < ref_len && !ref_valid);
        if (job_on && k >= int'(CC) + 1 && !done_q) begin
            if (!dp_running) run_idle++;
            if (starve) starved++;
        end
        if (sqg_valid && sqg_ready) begin sqi++; sq_hs++; end
        if (ref_valid && ref_ready) begin rfi++; rf_hs++; end
        if (dp_rst) begin
            steps  = 0;
            done_q = 1'b0;
        end else if (dp_running && !done_q) begin
            fed_sq.push_back(dp_squiggle);
            fed_rf.push_back(dp_rword);
            steps++;
            if (steps >= int'(SQ) + ref_len) done_q = 1'b1;
        end
        if (res_valid && res_k < 0) res_k = k;
        k++;
        @(negedge clk);
    endtask

    task automatic setup_job(input int len, input bit fresh);
        if (fresh) begin
            for (int i = 0; i < int'(SQ); i++) sq_mem[i] = W'($urandom_range(255));
            for (int j = 0; j < len; j++) rf_mem[j] = W'($urandom_range(255));
        end
        ref_len = len;
        gold = (len > 0) ? dtw(len) : '1;
        sqi = 0; rfi = 0; sq_hs = 0; rf_hs = 0; run_idle = 0; starved = 0; res_k = -1;
        fed_sq.delete();
        fed_rf.delete();
        start = 1'b1;
        start_ref_len = len;
        k = -1;
        job_on = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic do_job(input int len, input bit fresh, input int glo, input int ghi,
                          input bit rg, input int hold);
        int bad;
        logic [W-1:0] es, er;
        gap_lo = glo; gap_hi = ghi; rand_gaps = rg;
        setup_job(len, fresh);
        while (res_k < 0 && k < 400) cycle();
        rand_gaps = 1'b0; gap_lo = 1000; gap_hi = 0;
        chk("result_timeout", res_k >= 0, 1);
        chk("latency", res_k, int'(CC) + 3 + int'(SQ) + len + starved);
        chk("res_minval", res_minval, gold);
        chk("res_position", res_position, len);
        chk("res_err", res_err, 0);
        chk("stall_count", stall_count, starved);
        chk("idle_run_cycles", run_idle, starved);
        chk("sqg_handshakes", sq_hs, SQ);
        chk("ref_handshakes", rf_hs, len);
        chk("dp_ref_len", dp_ref_len, len);
        chk("fed_len", fed_sq.size(), int'(SQ) + len);
        bad = 0;
        for (int i = 0; i < fed_sq.size(); i++) begin
            es = (i == 0) ? '0 : ((i <= int'(SQ)) ? sq_mem[i-1] : '0);
            er = (i == 0) ? '0 : ((i <= len) ? rf_mem[i-1] : '1);
            if (fed_sq[i] !== es || fed_rf[i] !== er) bad++;
        end
        chk("fed_samples", bad, 0);
        for (int i = 0; i < hold; i++) begin
            if (i == 3) begin start = 1'b1; start_ref_len = 3; end
            cycle();
            start = 1'b0;
            chk("hold_valid", res_valid, 1);
            chk("hold_minval", res_minval, gold);
            chk("hold_position", res_position, len);
            chk("hold_busy", busy, 1);
        end
        res_ready = 1'b1;
        cycle();
        res_ready = 1'b0;
        chk("res_valid_drop", res_valid, 0);
        chk("idle_after_ready", busy, 0);
        cycle();
        chk("start_not_latched", busy, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort_s = 1'b0; res_ready = 1'b0; start_ref_len = '0;
        sqg_valid = 1'b0; ref_valid = 1'b0; sqg_data = '0; ref_data = '0; dp_done = 1'b0;
        gap_lo = 1000; gap_hi = 0; rand_gaps = 1'b0; job_on = 1'b0; done_q = 1'b0;
        k = 0; steps = 0; ref_len = 0; sqi = 0; rfi = 0; gold = '1; res_k = -1;
        repeat (2) @(negedge clk);
        chk("rst_dp_rst", dp_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_minval", res_minval, 16'hFFFF);
        chk("rst_valid", res_valid, 0);
        chk("rst_stall", stall_count, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean job, then the same job with a three-cycle reference gap.
        do_job(6, 1'b1, 1000, 0, 1'b0, 0);
        do_job(6, 1'b0, 5, 8, 1'b0, 0);
        chk("gap_stalls", stall_count, 3);

        // Zero-length job is rejected straight to the result port.
        setup_job(0, 1'b0);
        chk("zero_valid", res_valid, 1);
        chk("zero_err", res_err, 1);
        chk("zero_minval", res_minval, 16'hFFFF);
        chk("zero_position", res_position, 0);
        cycle();
        chk("zero_hs", sq_hs + rf_hs, 0);
        res_ready = 1'b1;
        cycle();
        res_ready = 1'b0;
        chk("zero_idle", busy, 0);

        // Abort five cycles into the run.
        setup_job(6, 1'b0);
        while (k < int'(CC) + 1 + 5) cycle();
        abort_s = 1'b1;
        cycle();
        abort_s = 1'b0;
        job_on = 1'b0;
        chk("abort_sqg_ready", sqg_ready, 0);
        chk("abort_ref_ready", ref_ready, 0);
        chk("abort_running", dp_running, 0);
        chk("abort_clr0", dp_rst, 1);
        cycle();
        chk("abort_clr1", dp_rst, 1);
        cycle();
        chk("abort_clr_end", dp_rst, 0);
        chk("abort_idle", busy, 0);
        repeat (4) cycle();
        chk("abort_no_result", res_k, -1);
        do_job(6, 1'b0, 1000, 0, 1'b0, 0);

        // Result held back by the consumer; a start in that window is dropped.
        do_job(7, 1'b1, 1000, 0, 1'b0, 10);

        // Reset pulsed in the middle of a run.
        setup_job(6, 1'b1);
        while (k < 6) cycle();
        rst_n = 1'b0;
        #1;
        job_on = 1'b0;
        chk("arst_dp_rst", dp_rst, 1);
        chk("arst_busy", busy, 0);
        chk("arst_readies", {sqg_ready, ref_ready}, 0);
        chk("arst_running", dp_running, 0);
        chk("arst_minval", res_minval, 16'hFFFF);
        chk("arst_position", res_position, 0);
        chk("arst_ref_len", dp_ref_len, 0);
        chk("arst_stall", stall_count, 0);
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("arst_release_idle", busy, 0);
        chk("arst_release_dp_rst", dp_rst, 0);
        do_job(5, 1'b1, 1000, 0, 1'b0, 0);

        // Randomized jobs with random starvation on both streams.
        for (int r = 0; r < 5; r++) begin
            do_job(int'($urandom_range(12, 1)), 1'b1, 1000, 0, 1'b1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
